// File: rtl/b01_serial_adder_seq.sv
// b01_serial_adder_seq: accepts a parallel operand pair, streams it LSB-first
// onto LINE1/LINE2, accumulates the serial sum and carry, and returns the
// parallel sum plus unsigned carry-out over a valid/ready handshake.
module b01_serial_adder_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_SUM,
    output logic             OUT_OVERFLW,
    output logic             LINE1,
    output logic             LINE2,
    output logic             OUTP,
    output logic             BUSY
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] res_next;

    // Full-adder slice on the current serial bits and the next result image
    always_comb begin
        sum_bit    = sa[0] ^ sb[0] ^ carry;
        carry_next = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
        res_next   = {sum_bit, res[WIDTH-1:1]};
    end

    // Serial lines show the operand LSBs only while shifting
    always_comb begin
        LINE1 = (state == ST_SHIFT) & sa[0];
        LINE2 = (state == ST_SHIFT) & sb[0];
    end

    // Control FSM with registered handshake/status outputs and the datapath registers
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            sa          <= '0;
            sb          <= '0;
            res         <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            IN_READY    <= 1'b1;
            OUT_VALID   <= 1'b0;
            OUT_SUM     <= '0;
            OUT_OVERFLW <= 1'b0;
            OUTP        <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        sa       <= IN_A;
                        sb       <= IN_B;
                        carry    <= 1'b0;
                        cnt      <= '0;
                        state    <= ST_SHIFT;
                        IN_READY <= 1'b0;
                        BUSY     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    carry <= carry_next;
                    OUTP  <= sum_bit;
                    res   <= res_next;
                    sa    <= {1'b0, sa[WIDTH-1:1]};
                    sb    <= {1'b0, sb[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state       <= ST_HOLD;
                        OUT_SUM     <= res_next;
                        OUT_OVERFLW <= carry_next;
                        OUT_VALID   <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // IN_READY rises only once IDLE is reached, so no same-cycle bypass
                    if (OUT_READY) begin
                        state     <= ST_IDLE;
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                        BUSY      <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
